// File: rtl/ev_sweep_gen.sv
// Per-set LLC eviction counter with ping-pong banks and running sum / sum-of-squares totals.
// A sweep request freezes the active bank and streams one record per set over valid/ready.
module ev_sweep_gen #(
  parameter int SETS  = 1024,
  parameter int SET_W = 10,
  parameter int EV_W  = 15,
  parameter int SQ_W  = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_evict_valid,
  input  logic [SET_W-1:0] io_evict_set,
  input  logic             io_sweep_req,
  input  logic             io_traceout_ready,
  output logic             io_traceout_valid,
  output logic [SET_W-1:0] io_traceout_bits_set,
  output logic [EV_W-1:0]  io_traceout_bits_ev,
  output logic [EV_W-1:0]  io_traceout_bits_evSum,
  output logic [SQ_W-1:0]  io_traceout_bits_evSqSum,
  output logic             io_busy
);

  typedef enum logic [1:0] {IDLE, SWAP, SWEEP} state_t;

  localparam logic [EV_W-1:0]  EV_MAX   = '1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  logic [EV_W-1:0] cnt_mem [2][SETS];
  logic [SETS-1:0] cnt_vld [2];

  state_t           state;
  logic             act_bank;
  logic             pending;
  logic [SET_W:0]   fetch_idx;

  logic             s1_valid;
  logic             s1_bank;
  logic [SET_W-1:0] s1_set;
  logic [EV_W-1:0]  s1_cnt;
  logic [EV_W-1:0]  run_sum;
  logic [SQ_W-1:0]  run_sq;

  logic             s1_upd;
  logic [EV_W-1:0]  s1_inc;
  logic [SQ_W:0]    sq_add;
  logic [EV_W-1:0]  run_sum_nxt;
  logic [SQ_W-1:0]  run_sq_nxt;
  logic [EV_W-1:0]  s0_rd;
  logic             s0_fwd;
  logic             swp_bank;
  logic             hs;
  logic             last_hs;
  logic             fetch;
  logic [EV_W-1:0]  fetch_rd;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s1_upd      = s1_valid && (s1_cnt != EV_MAX);
    s1_inc      = s1_cnt + EV_W'(1);
    sq_add      = {1'b0, run_sq} + (SQ_W+1)'({s1_cnt, 1'b1});
    run_sum_nxt = run_sum;
    run_sq_nxt  = run_sq;
    if (s1_upd) begin
      if (run_sum != EV_MAX) run_sum_nxt = run_sum + EV_W'(1);
      run_sq_nxt = sq_add[SQ_W] ? '1 : sq_add[SQ_W-1:0];
    end

    // An entry whose valid bit is clear reads as zero, whatever the RAM holds.
    s0_rd  = cnt_vld[act_bank][io_evict_set] ? cnt_mem[act_bank][io_evict_set] : '0;
    s0_fwd = s1_upd && (s1_bank == act_bank) && (s1_set == io_evict_set);

    swp_bank = ~act_bank;
    hs       = io_traceout_valid && io_traceout_ready;
    last_hs  = hs && (io_traceout_bits_set == LAST_SET);
    fetch    = (state == SWEEP) && !fetch_idx[SET_W] && (!io_traceout_valid || io_traceout_ready);
    fetch_rd = cnt_vld[swp_bank][fetch_idx[SET_W-1:0]] ?
               cnt_mem[swp_bank][fetch_idx[SET_W-1:0]] : '0;
  end

  assign io_busy = (state != IDLE) || pending;

  // NOTE: the counter RAM has no reset; the per-entry valid bits below give clear-on-reset.
  always_ff @(posedge clock) begin
    if (s1_upd) cnt_mem[s1_bank][s1_set] <= s1_inc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_vld[0] <= '0;
      cnt_vld[1] <= '0;
    end else begin
      if (hs)     cnt_vld[swp_bank][io_traceout_bits_set] <= 1'b0;
      if (s1_upd) cnt_vld[s1_bank][s1_set]                <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_set   <= '0;
      s1_cnt   <= '0;
      run_sum  <= '0;
      run_sq   <= '0;
    end else begin
      s1_valid <= io_evict_valid;
      if (io_evict_valid) begin
        s1_bank <= act_bank;
        s1_set  <= io_evict_set;
        s1_cnt  <= s0_fwd ? s1_inc : s0_rd;
      end
      // The SWAP cycle hands the retiring S1 update to the snapshot and starts a fresh epoch.
      if (state == SWAP) begin
        run_sum <= '0;
        run_sq  <= '0;
      end else begin
        run_sum <= run_sum_nxt;
        run_sq  <= run_sq_nxt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      act_bank                 <= 1'b0;
      pending                  <= 1'b0;
      fetch_idx                <= '0;
      io_traceout_valid        <= 1'b0;
      io_traceout_bits_set     <= '0;
      io_traceout_bits_ev      <= '0;
      io_traceout_bits_evSum   <= '0;
      io_traceout_bits_evSqSum <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The bank flips on entry to SWAP, so SWAP-cycle evictions land in the new epoch.
          if (io_sweep_req || pending) begin
            state    <= SWAP;
            act_bank <= ~act_bank;
          end
        end
        SWAP: begin
          io_traceout_bits_evSum   <= run_sum_nxt;
          io_traceout_bits_evSqSum <= run_sq_nxt;
          fetch_idx                <= '0;
          pending                  <= io_sweep_req;
          state                    <= SWEEP;
        end
        SWEEP: begin
          if (io_sweep_req) pending <= 1'b1;
          if (last_hs) begin
            if (pending) begin
              state    <= SWAP;
              act_bank <= ~act_bank;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (fetch) begin
        io_traceout_valid    <= 1'b1;
        io_traceout_bits_set <= fetch_idx[SET_W-1:0];
        io_traceout_bits_ev  <= fetch_rd;
        fetch_idx            <= fetch_idx + (SET_W+1)'(1);
      end else if (hs) begin
        io_traceout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ev_sweep_gen.sv
// Directed bench for ev_sweep_gen: table of eviction patterns with hand-computed sweep results,
// plus hand-written sequences for concurrent epochs, saturation and reset mid-sweep.
module tb_ev_sweep_gen;

  localparam int SETS  = 1024;
  localparam int SET_W = 10;
  localparam int EV_W  = 15;
  localparam int SQ_W  = 40;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_evict_valid;
  logic [SET_W-1:0] io_evict_set;
  logic             io_sweep_req;
  logic             io_traceout_ready;
  logic             io_traceout_valid;
  logic [SET_W-1:0] io_traceout_bits_set;
  logic [EV_W-1:0]  io_traceout_bits_ev;
  logic [EV_W-1:0]  io_traceout_bits_evSum;
  logic [SQ_W-1:0]  io_traceout_bits_evSqSum;
  logic             io_busy;

  ev_sweep_gen #(.SETS(SETS), .SET_W(SET_W), .EV_W(EV_W), .SQ_W(SQ_W)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_evict_valid          (io_evict_valid),
    .io_evict_set            (io_evict_set),
    .io_sweep_req            (io_sweep_req),
    .io_traceout_ready       (io_traceout_ready),
    .io_traceout_valid       (io_traceout_valid),
    .io_traceout_bits_set    (io_traceout_bits_set),
    .io_traceout_bits_ev     (io_traceout_bits_ev),
    .io_traceout_bits_evSum  (io_traceout_bits_evSum),
    .io_traceout_bits_evSqSum(io_traceout_bits_evSqSum),
    .io_busy                 (io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int     set_a;
    int     n_a;
    int     set_b;
    int     n_b;
    int     mode;     // 0: gapped, 1: back-to-back a then b, 2: interleaved back-to-back
    bit     bp;
    int     exp_sum;
    longint exp_sq;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     exp_ev [SETS];
  longint exp_sum;
  longint exp_sq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < SETS; i++) exp_ev[i] = 0;
    exp_sum = 0;
    exp_sq  = 0;
  endtask

  task automatic ev1(input int set);
    io_evict_valid = 1'b1;
    io_evict_set   = SET_W'(set);
    @(negedge clock);
    io_evict_valid = 1'b0;
  endtask

  // Called at a negedge; collects one full sweep and compares it against exp_*.
  task automatic do_sweep(input string tag, input bit send_req, input bit chk_lat,
                          input bit bp, input bit inject, input bit exp_follow);
    int k, got, lat, bad, unstable;
    bit stalled, r;
    logic [SET_W-1:0] sv_set;
    logic [EV_W-1:0]  sv_ev, sv_sum;
    logic [SQ_W-1:0]  sv_sq;
    k = 0; got = 0; lat = -1; bad = 0; unstable = 0; stalled = 0;
    sv_set = '0; sv_ev = '0; sv_sum = '0; sv_sq = '0;
    if (send_req) io_sweep_req = 1'b1;
    while (got < SETS && k < 6000) begin
      @(negedge clock);
      k++;
      io_sweep_req   = inject && (k == 100 || k == 200);
      io_evict_valid = inject && (k >= 20 && k < 26);
      io_evict_set   = SET_W'(1);
      r = bp ? (((k % 4) == 0 || (k % 4) == 3) ^ ($urandom_range(0, 4) == 0)) : 1'b1;
      io_traceout_ready = r;
      if (send_req && k == 1) check($sformatf("%s_busy_rise", tag), io_busy, 1);
      if (io_traceout_valid && lat < 0) lat = k;
      if (stalled) begin
        if (!io_traceout_valid || io_traceout_bits_set !== sv_set ||
            io_traceout_bits_ev !== sv_ev || io_traceout_bits_evSum !== sv_sum ||
            io_traceout_bits_evSqSum !== sv_sq) unstable++;
      end
      stalled = 1'b0;
      if (io_traceout_valid) begin
        if (r) begin
          if (io_traceout_bits_set !== SET_W'(got) ||
              io_traceout_bits_ev !== EV_W'(exp_ev[got]) ||
              io_traceout_bits_evSum !== EV_W'(exp_sum) ||
              io_traceout_bits_evSqSum !== SQ_W'(exp_sq)) bad++;
          got++;
        end else begin
          stalled = 1'b1;
          sv_set = io_traceout_bits_set;
          sv_ev  = io_traceout_bits_ev;
          sv_sum = io_traceout_bits_evSum;
          sv_sq  = io_traceout_bits_evSqSum;
        end
      end
    end
    io_sweep_req      = 1'b0;
    io_evict_valid    = 1'b0;
    io_traceout_ready = 1'b1;
    check($sformatf("%s_count", tag), got, SETS);
    check($sformatf("%s_bad_records", tag), bad, 0);
    if (bp) check($sformatf("%s_unstable", tag), unstable, 0);
    if (chk_lat) check($sformatf("%s_latency", tag), lat, 3);
    @(negedge clock);
    check($sformatf("%s_valid_after", tag), io_traceout_valid, 0);
    check($sformatf("%s_busy_after", tag), io_busy, exp_follow);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{set_a: 0,   n_a: 0, set_b: 0,    n_b: 0, mode: 0, bp: 0, exp_sum: 0, exp_sq: 0};
    vecs[1] = '{set_a: 5,   n_a: 3, set_b: 700,  n_b: 2, mode: 0, bp: 0, exp_sum: 5, exp_sq: 13};
    vecs[2] = '{set_a: 9,   n_a: 4, set_b: 0,    n_b: 0, mode: 1, bp: 0, exp_sum: 4, exp_sq: 16};
    vecs[3] = '{set_a: 0,   n_a: 1, set_b: 1023, n_b: 2, mode: 1, bp: 1, exp_sum: 3, exp_sq: 5};
    vecs[4] = '{set_a: 512, n_a: 5, set_b: 513,  n_b: 3, mode: 2, bp: 0, exp_sum: 8, exp_sq: 34};

    io_evict_valid    = 1'b0;
    io_evict_set      = '0;
    io_sweep_req      = 1'b0;
    io_traceout_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid",   io_traceout_valid, 0);
    check("rst_set",     io_traceout_bits_set, 0);
    check("rst_ev",      io_traceout_bits_ev, 0);
    check("rst_evSum",   io_traceout_bits_evSum, 0);
    check("rst_evSqSum", io_traceout_bits_evSqSum, 0);
    check("rst_busy",    io_busy, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      clear_exp();
      exp_ev[vecs[v].set_a] += vecs[v].n_a;
      exp_ev[vecs[v].set_b] += vecs[v].n_b;
      exp_sum = vecs[v].exp_sum;
      exp_sq  = vecs[v].exp_sq;
      case (vecs[v].mode)
        0: begin
          for (int i = 0; i < vecs[v].n_a; i++) begin ev1(vecs[v].set_a); @(negedge clock); end
          for (int i = 0; i < vecs[v].n_b; i++) begin ev1(vecs[v].set_b); @(negedge clock); end
        end
        1: begin
          for (int i = 0; i < vecs[v].n_a; i++) ev1(vecs[v].set_a);
          for (int i = 0; i < vecs[v].n_b; i++) ev1(vecs[v].set_b);
        end
        default: begin
          for (int i = 0; i < 5; i++) begin
            if (i < vecs[v].n_a) ev1(vecs[v].set_a);
            if (i < vecs[v].n_b) ev1(vecs[v].set_b);
          end
        end
      endcase
      repeat (3) @(negedge clock);
      do_sweep($sformatf("vec%0d", v), 1'b1, 1'b1, vecs[v].bp, 1'b0, 1'b0);
    end

    // Evictions and two requests during a sweep: first sweep untouched, exactly one follow-up.
    clear_exp();
    do_sweep("concur_first", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    clear_exp();
    exp_ev[1] = 6;
    exp_sum   = 6;
    exp_sq    = 36;
    do_sweep("concur_follow", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
    check("concur_no_third_busy",  io_busy, 0);
    check("concur_no_third_valid", io_traceout_valid, 0);

    // Counter and both totals saturate together.
    for (int i = 0; i < 32768; i++) ev1(0);
    repeat (3) @(negedge clock);
    clear_exp();
    exp_ev[0] = 32767;
    exp_sum   = 32767;
    exp_sq    = 64'd1073676289;
    do_sweep("sat", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    ev1(3);
    ev1(3);
    repeat (2) @(negedge clock);
    io_sweep_req = 1'b1;
    @(negedge clock);
    io_sweep_req = 1'b0;
    repeat (60) @(negedge clock);
    check("midrst_valid_before", io_traceout_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", io_traceout_valid, 0);
    check("midrst_busy",  io_busy, 0);
    check("midrst_evSum", io_traceout_bits_evSum, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    clear_exp();
    do_sweep("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ev_sweep_gen.md
Name: ev_sweep_gen

Overview:
- Upstream feeder of the attack-detector trace stage.
- Counts LLC evictions per cache set into a ping-pong counter bank, while keeping running totals: sum of per-set counts and sum of squared per-set counts.
- On a sweep request, freezes the active bank and snapshots the totals, then streams one record per set (set 0..SETS-1) over a valid/ready port. The record carries that set's count plus the frozen global totals.

Parameters:
- SETS, 1024: number of cache sets; power of two.
- SET_W, 10: log2(SETS).
- EV_W, 15: per-set counter width and evSum width.
- SQ_W, 40: evSqSum width.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_evict_valid  in  1  one eviction this cycle; no backpressure.
- io_evict_set  in  SET_W  set index of the eviction.
- io_sweep_req  in  1  pulse: close the epoch and start a sweep.
- io_traceout_ready  in  1  downstream ready.
- io_traceout_valid  out  1  record valid.
- io_traceout_bits_set  out  SET_W  set index of the record.
- io_traceout_bits_ev  out  EV_W  eviction count of that set for the closed epoch.
- io_traceout_bits_evSum  out  EV_W  frozen sum of all counts; constant for the whole sweep.
- io_traceout_bits_evSqSum  out  SQ_W  frozen sum of squared counts; constant for the whole sweep.
- io_busy  out  1  high while in SWEEP or while a request is pending.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: valid=0, set=0, ev=0, evSum=0, evSqSum=0, busy=0.
  - State: both banks are logically zero (clear-on-reset, or a reset-time clear sweep that keeps busy=1 until done). Active bank = 0, running totals = 0, pending = 0, FSM = IDLE.
- Eviction path (2-stage read-modify-write on the active bank):
  - S0 reads cnt[set].
  - S1 writes c' = c+1 and adds 2c+1 to runSqSum and 1 to runSum.
  - Forwarding: if S0.set == S1.set, S0 uses S1's c'. Back-to-back hits to one set every cycle must count exactly.
  - Saturation: if c == 2^EV_W-1, no write and no totals update.
  - runSum saturates at 2^EV_W-1; runSqSum saturates at 2^SQ_W-1; each saturates independently.
  - Evictions are accepted in every state and always go to the active bank.
- FSM states: IDLE, SWAP, SWEEP.
  - IDLE -> SWAP on io_sweep_req, or when pending=1.
  - SWAP is taken only in a cycle where S1 is empty or drains this cycle. Otherwise it waits.
  - In SWAP, one cycle:
    - snapshot the totals (including any S1 update retiring this cycle);
    - clear runSum and runSqSum;
    - toggle the active bank;
    - set the sweep index to 0;
    - clear pending.
  - Evictions arriving in the SWAP cycle go to the new bank.
  - SWAP -> SWEEP.
- SWEEP:
  - Reads the frozen bank with read-ahead, so io_traceout_valid rises 2 cycles after the SWAP cycle.
  - Sustains 1 record/cycle while ready=1.
  - The frozen entry is cleared when its record handshakes.
  - Records stay stable while valid && !ready.
  - After the handshake of set SETS-1: valid drops next cycle and FSM -> IDLE (or -> SWAP if pending).
- io_sweep_req handling:
  - In SWAP/SWEEP: sets pending (one deep).
  - Further requests while pending=1 are ignored.
  - A request in IDLE with pending=1 is merged.
- Invariant: sum of ev over a sweep == evSum, unless evSum saturated.
- There is no mid-operation reset path other than the asynchronous reset, which aborts a sweep immediately.

Test Plan:
- Idle sweep: reset, then sweep_req -> 1024 records, set 0..1023, all ev=0, evSum=0, evSqSum=0; first valid 2 cycles after SWAP; busy falls after set 1023.
- Known counts: 3 evictions to set 5 and 2 to set 700, then sweep -> set 5 ev=3, set 700 ev=2, all others 0; every record has evSum=5, evSqSum=13.
- Same-set back-to-back: 4 consecutive cycles of evict set 9, then sweep -> set 9 ev=4, evSqSum=16.
- Concurrent epoch: during a sweep, 6 evictions to set 1; sweep_req twice mid-sweep -> exactly one follow-up sweep with set 1 ev=6, evSum=6, evSqSum=36; the first sweep is unaffected.
- Backpressure: ready toggled 1,0,0,1 pseudo-randomly -> bits stable while stalled; no duplicates or gaps in set order; count==1024.
- Saturation: 32768 evictions to set 0 -> ev=32767, evSum=32767, evSqSum=32767^2=1073676289; an async reset mid-sweep -> valid=0 within the reset, and the next sweep is all zeros.
